// File: rtl/iir_deemph_if.sv
`default_nettype none
// ============================================================================
// Module      : iir_deemph_if
// Description : Sample-stream bundle for the de-emphasis filter. It carries
//               the FWFT input FIFO head/pop/empty signals and the output
//               FIFO data/push/full signals.
//               master : filter side (pops input, pushes output)
//               slave  : FIFO/environment side
// Ports       : x_in, x_empty, x_rd_en   - input FIFO (FWFT)
//               y_out, y_out_full, y_wr_en - output FIFO
// Revision    : 1.0 - initial release
// ============================================================================
interface iir_deemph_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] x_in;
  logic                  x_rd_en;
  logic                  x_empty;
  logic [DATA_WIDTH-1:0] y_out;
  logic                  y_out_full;
  logic                  y_wr_en;

  modport master (
    input  x_in, x_empty, y_out_full,
    output x_rd_en, y_out, y_wr_en
  );

  modport slave (
    output x_in, x_empty, y_out_full,
    input  x_rd_en, y_out, y_wr_en
  );
endinterface
`default_nettype wire

// File: rtl/iir_deemph.sv
`default_nettype none
// ============================================================================
// Module      : iir_deemph
// Description : Two-tap IIR de-emphasis filter,
//               y[n] = deq(X0*x[n]) + deq(X1*x[n-1]) + deq(Y1*y[n-1]),
//               with a single multiplier time-shared over three cycles and
//               optional output decimation. One sample in flight at a time.
// Ports       : clock - rising-edge clock
//               reset - synchronous active-high reset
//               bus   - iir_deemph_if.master (input FIFO pop side and
//                       output FIFO push side)
// Revision    : 1.0 - initial release
// ============================================================================
module iir_deemph #(
  parameter int DATA_WIDTH = 32,
  parameter int QUANT_BITS = 10,
  parameter int X_COEFF0   = 178,
  parameter int X_COEFF1   = 178,
  parameter int Y_COEFF1   = -666,
  parameter int DECIMATION = 1
) (
  input  wire logic     clock,
  input  wire logic     reset,
  iir_deemph_if.master  bus
);

  localparam int c_dec_w = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [c_dec_w-1:0] c_dec_last = c_dec_w'(DECIMATION - 1);
  localparam logic signed [DATA_WIDTH-1:0] c_coef_x0 = DATA_WIDTH'(X_COEFF0);
  localparam logic signed [DATA_WIDTH-1:0] c_coef_x1 = DATA_WIDTH'(X_COEFF1);
  localparam logic signed [DATA_WIDTH-1:0] c_coef_y1 = DATA_WIDTH'(Y_COEFF1);
  // Bias added to negative products so the shift truncates toward zero.
  localparam logic signed [DATA_WIDTH-1:0] c_round =
    DATA_WIDTH'((1 << QUANT_BITS) - 1);

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_MAC   = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [DATA_WIDTH-1:0] r_x0;
  logic signed [DATA_WIDTH-1:0] r_x1;
  logic signed [DATA_WIDTH-1:0] r_y_prev;
  logic signed [DATA_WIDTH-1:0] r_acc;
  logic        [1:0]            r_mac_cnt;
  logic        [c_dec_w-1:0]    r_dec_cnt;
  logic        [DATA_WIDTH-1:0] r_y_out;
  logic                         r_y_wr_en;

  logic signed [DATA_WIDTH-1:0] w_coef;
  logic signed [DATA_WIDTH-1:0] w_opnd;
  logic signed [DATA_WIDTH-1:0] w_prod;
  logic signed [DATA_WIDTH-1:0] w_deq;
  logic signed [DATA_WIDTH-1:0] w_sum;
  logic                         w_mac_last;
  logic                         w_dec_last;
  logic                         w_rd;
  logic                         w_fire;

  // Multiplier operand select: one tap per MAC cycle.
  always_comb begin
    w_coef = c_coef_x0;
    w_opnd = r_x0;
    case (r_mac_cnt)
      2'd1: begin
        w_coef = c_coef_x1;
        w_opnd = r_x1;
      end
      2'd2: begin
        w_coef = c_coef_y1;
        w_opnd = r_y_prev;
      end
      default: ;
    endcase
  end

  // Product is evaluated at DATA_WIDTH, which keeps exactly the low bits.
  assign w_prod = w_coef * w_opnd;
  assign w_deq  = w_prod[DATA_WIDTH-1] ? ((w_prod + c_round) >>> QUANT_BITS)
                                       : (w_prod >>> QUANT_BITS);
  assign w_sum  = r_acc + w_deq;

  assign w_mac_last = (r_mac_cnt == 2'd2);
  assign w_dec_last = (r_dec_cnt == c_dec_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_READ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd        = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      S_READ: begin
        if (!bus.x_empty) begin
          w_rd        = 1'b1;
          w_state_nxt = S_MAC;
        end
      end
      S_MAC: begin
        if (w_mac_last) begin
          w_state_nxt = w_dec_last ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (!bus.y_out_full) begin
          w_fire      = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      default: w_state_nxt = S_READ;
    endcase
    if (reset) begin
      w_rd = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_x0      <= '0;
      r_x1      <= '0;
      r_y_prev  <= '0;
      r_acc     <= '0;
      r_mac_cnt <= '0;
      r_dec_cnt <= '0;
      r_y_out   <= '0;
      r_y_wr_en <= 1'b0;
    end else begin
      r_y_wr_en <= 1'b0;
      if (w_rd) begin
        r_x1      <= r_x0;
        r_x0      <= bus.x_in;
        r_acc     <= '0;
        r_mac_cnt <= '0;
      end
      if (r_state == S_MAC) begin
        r_acc     <= w_sum;
        r_mac_cnt <= r_mac_cnt + 2'd1;
        if (w_mac_last) begin
          // y_prev doubles as the result register: it is not touched again
          // before the write that follows.
          r_y_prev  <= w_sum;
          r_dec_cnt <= w_dec_last ? '0 : r_dec_cnt + 1'b1;
        end
      end
      if (w_fire) begin
        r_y_wr_en <= 1'b1;
        r_y_out   <= r_y_prev;
      end
    end
  end

  assign bus.x_rd_en = w_rd;
  assign bus.y_out   = r_y_out;
  assign bus.y_wr_en = r_y_wr_en;

endmodule
`default_nettype wire
